vein_overlap_accum: RTL

VEIN_OVERLAP_ACCUM -- requirements
Module: vein_overlap_accum

---
 rtl/vein_match_pkg.sv | 14 +
 rtl/popcount16.sv | 16 +
 rtl/vein_overlap_accum.sv | 116 +++++++++++
 3 files changed

// File: rtl/vein_match_pkg.sv
// Shared definitions for the vein-template matcher: word width and controller state encoding.
package vein_match_pkg;

  localparam int DATA_W = 16;
  localparam int PC_W   = 5;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    OUT   = 2'd3
  } state_t;

endpackage

// File: rtl/popcount16.sv
// Combinational population count of one template word.
module popcount16
  import vein_match_pkg::*;
(
  input  logic [DATA_W-1:0] word,
  output logic [PC_W-1:0]   count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < DATA_W; i++) begin
      count = count + PC_W'(word[i]);
    end
  end

endmodule

// File: rtl/vein_overlap_accum.sv
// Accumulates AND/OR overlap of two bit templates, hands the ratio to an external
// divider and returns the quotient as a match score with a template-length error flag.
module vein_overlap_accum
  import vein_match_pkg::*;
#(
  parameter int WORDS    = 64,
  parameter int SCALE_SH = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [DATA_W-1:0] ref_word,
  input  logic [DATA_W-1:0] probe_word,
  output logic              div_enable,
  output logic [DATA_W-1:0] div_dividend,
  output logic [DATA_W-1:0] div_divisor,
  input  logic              div_done,
  input  logic [DATA_W-1:0] div_quotient,
  output logic              score_valid,
  output logic [DATA_W-1:0] score,
  output logic              err_len
);

  localparam int CW = $clog2(WORDS * DATA_W + 1);
  localparam int DW = CW + SCALE_SH;

  // Clamp the scaled AND count to the divider's dividend range.
  function automatic logic [DATA_W-1:0] sat_dividend(input logic [CW-1:0] cnt);
    logic [DW-1:0] v;
    v = DW'(cnt) << SCALE_SH;
    if (|(v >> DATA_W)) return '1;
    return DATA_W'(v);
  endfunction

  state_t            state, state_nxt;
  logic [CW-1:0]     and_cnt, or_cnt, word_cnt;
  logic [CW-1:0]     and_nxt, or_nxt, word_nxt;
  logic              err_flag;
  logic [DATA_W-1:0] and_word, or_word;
  logic [PC_W-1:0]   pc_and, pc_or;
  logic              accept, at_end;

  assign and_word = ref_word & probe_word;
  assign or_word  = ref_word | probe_word;

  popcount16 u_pc_and (.word(and_word), .count(pc_and));
  popcount16 u_pc_or  (.word(or_word),  .count(pc_or));

  assign accept   = in_valid & in_ready;
  assign and_nxt  = and_cnt + CW'(pc_and);
  assign or_nxt   = or_cnt + CW'(pc_or);
  assign word_nxt = word_cnt + CW'(1);
  assign at_end   = (word_nxt == CW'(WORDS));

  assign in_ready    = (state == ACCUM);
  assign div_enable  = (state == ISSUE) && (or_cnt != '0);
  assign score_valid = (state == OUT);
  assign err_len     = (state == OUT) && err_flag;

  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM:   if (accept && (in_last || at_end)) state_nxt = ISSUE;
      ISSUE:   state_nxt = (or_cnt != '0) ? WAIT : OUT;
      WAIT:    if (div_done) state_nxt = OUT;
      OUT:     state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ACCUM;
      and_cnt      <= '0;
      or_cnt       <= '0;
      word_cnt     <= '0;
      err_flag     <= 1'b0;
      div_dividend <= '0;
      div_divisor  <= '0;
      score        <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        ACCUM: begin
          if (accept) begin
            and_cnt  <= and_nxt;
            or_cnt   <= or_nxt;
            word_cnt <= word_nxt;
            // in_last on the wrong beat, or no in_last on beat WORDS, are both length errors.
            if (in_last != at_end) err_flag <= 1'b1;
            if (in_last || at_end) begin
              div_dividend <= sat_dividend(and_nxt);
              div_divisor  <= DATA_W'(or_nxt);
            end
          end
        end
        ISSUE: begin
          if (or_cnt == '0) score <= '0;
        end
        WAIT: begin
          if (div_done) score <= div_quotient;
        end
        OUT: begin
          and_cnt  <= '0;
          or_cnt   <= '0;
          word_cnt <= '0;
          err_flag <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
